// File: rtl/stage_tl.sv
// Translation-lookaside stage: registers the EXTL bundle into TLC and owns a small fully associative DTLB.
// Optional STAGE_TL_FLUSH_EN adds a dtlb_flush input that invalidates every entry.
module stage_tl #(
   parameter int unsigned DTLB_ENTRIES = 4,
   parameter int unsigned PAGE_BITS    = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vm_en,
   input  logic        stall,
`ifdef STAGE_TL_FLUSH_EN
   input  logic        dtlb_flush,
`endif
   input  logic        ex_thread,
   input  logic        ex_isvalid,
   input  logic        ex_itlb_miss,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_data,
   input  logic [31:0] ex_mul,
   input  logic [31:0] ex_r2,
   input  logic [4:0]  ex_dst,
   input  logic        ex_isequal,
   input  logic        ex_flag_mem,
   input  logic        ex_flag_store,
   input  logic        ex_flag_isbyte,
   input  logic        ex_flag_mul,
   input  logic        ex_flag_reg,
   input  logic        ex_flag_jump,
   input  logic        ex_flag_branch,
   input  logic        ex_flag_iret,
   input  logic [1:0]  ex_flag_tlbwrite,
   input  logic [31:0] ex_rm4,
   output logic        c_thread,
   output logic        c_isvalid,
   output logic        c_itlb_miss,
   output logic [31:0] c_pc,
   output logic [31:0] c_data,
   output logic [31:0] c_mul,
   output logic [31:0] c_r2,
   output logic [4:0]  c_dst,
   output logic        c_isequal,
   output logic        c_flag_mem,
   output logic        c_flag_store,
   output logic        c_flag_isbyte,
   output logic        c_flag_mul,
   output logic        c_flag_reg,
   output logic        c_flag_jump,
   output logic        c_flag_branch,
   output logic        c_flag_iret,
   output logic [1:0]  c_flag_tlbwrite,
   output logic [31:0] c_rm4,
   output logic [31:0] c_paddr,
   output logic        c_dtlb_miss
);

   localparam int unsigned VPN_W = 32 - PAGE_BITS;
   localparam int unsigned IDX_W = $clog2(DTLB_ENTRIES);
   localparam logic [1:0]  TLBW_DTLB = 2'd2;

   logic [DTLB_ENTRIES-1:0] valid_q;
   logic [VPN_W-1:0]        vpn_q [DTLB_ENTRIES];
   logic [VPN_W-1:0]        ppn_q [DTLB_ENTRIES];
   logic [IDX_W-1:0]        rr_q;

   logic [DTLB_ENTRIES-1:0] match_c;
   logic                    hit_c;
   logic [IDX_W-1:0]        hit_idx_c;
   logic [VPN_W-1:0]        hit_ppn_c;
   logic                    has_free_c;
   logic [IDX_W-1:0]        free_idx_c;
   logic [31:0]             paddr_c;
   logic                    miss_c;
   logic                    wr_en_c;
   logic [IDX_W-1:0]        wr_idx_c;
   logic                    use_rr_c;
   logic                    flush_c;

`ifdef STAGE_TL_FLUSH_EN
   assign flush_c = dtlb_flush;
`else
   assign flush_c = 1'b0;
`endif

   // Lookup against pre-write contents and write-target selection
   always_comb begin
      match_c    = '0;
      hit_idx_c  = '0;
      hit_ppn_c  = '0;
      has_free_c = 1'b0;
      free_idx_c = '0;
      for (int unsigned i = 0; i < DTLB_ENTRIES; i++) begin
         match_c[i] = valid_q[i] && (vpn_q[i] == ex_data[31:PAGE_BITS]);
         if (match_c[i]) begin
            hit_idx_c = IDX_W'(i);
            hit_ppn_c = ppn_q[i];
         end
      end
      // descending scan so the lowest free index wins
      for (int i = int'(DTLB_ENTRIES) - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            has_free_c = 1'b1;
            free_idx_c = IDX_W'(i);
         end
      end
      hit_c    = (match_c != '0) && ((match_c & (match_c - DTLB_ENTRIES'(1))) == '0);
      paddr_c  = (vm_en && hit_c) ? {hit_ppn_c, ex_data[PAGE_BITS-1:0]} : ex_data;
      miss_c   = ex_isvalid && ex_flag_mem && vm_en && !hit_c;
      wr_en_c  = ex_isvalid && (ex_flag_tlbwrite == TLBW_DTLB) && !stall && !ex_itlb_miss;
      wr_idx_c = hit_c ? hit_idx_c : (has_free_c ? free_idx_c : rr_q);
      use_rr_c = wr_en_c && !hit_c && !has_free_c;
   end

   // TLB state; flush overrides a simultaneous write and ignores stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         rr_q    <= '0;
         for (int unsigned i = 0; i < DTLB_ENTRIES; i++) begin
            vpn_q[i] <= '0;
            ppn_q[i] <= '0;
         end
      end else if (flush_c) begin
         valid_q <= '0;
         rr_q    <= '0;
      end else if (wr_en_c) begin
         valid_q[wr_idx_c] <= 1'b1;
         vpn_q[wr_idx_c]   <= ex_data[31:PAGE_BITS];
         ppn_q[wr_idx_c]   <= ex_r2[VPN_W-1:0];
         if (use_rr_c) begin
            rr_q <= rr_q + IDX_W'(1);
         end
      end
   end

   // TLC output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_thread        <= 1'b0;
         c_isvalid       <= 1'b0;
         c_itlb_miss     <= 1'b0;
         c_pc            <= '0;
         c_data          <= '0;
         c_mul           <= '0;
         c_r2            <= '0;
         c_dst           <= '0;
         c_isequal       <= 1'b0;
         c_flag_mem      <= 1'b0;
         c_flag_store    <= 1'b0;
         c_flag_isbyte   <= 1'b0;
         c_flag_mul      <= 1'b0;
         c_flag_reg      <= 1'b0;
         c_flag_jump     <= 1'b0;
         c_flag_branch   <= 1'b0;
         c_flag_iret     <= 1'b0;
         c_flag_tlbwrite <= '0;
         c_rm4           <= '0;
         c_paddr         <= '0;
         c_dtlb_miss     <= 1'b0;
      end else if (!stall) begin
         c_thread        <= ex_thread;
         c_isvalid       <= ex_isvalid;
         c_itlb_miss     <= ex_itlb_miss;
         c_pc            <= ex_pc;
         c_data          <= ex_data;
         c_mul           <= ex_mul;
         c_r2            <= ex_r2;
         c_dst           <= ex_dst;
         c_isequal       <= ex_isequal;
         c_flag_mem      <= ex_flag_mem;
         c_flag_store    <= ex_flag_store;
         c_flag_isbyte   <= ex_flag_isbyte;
         c_flag_mul      <= ex_flag_mul;
         c_flag_reg      <= ex_flag_reg;
         c_flag_jump     <= ex_flag_jump;
         c_flag_branch   <= ex_flag_branch;
         c_flag_iret     <= ex_flag_iret;
         c_flag_tlbwrite <= ex_flag_tlbwrite;
         c_rm4           <= ex_rm4;
         c_paddr         <= paddr_c;
         c_dtlb_miss     <= miss_c;
      end
   end

endmodule

// File: doc/stage_tl.md
# stage_tl

Translation-lookaside stage of the datapath. It sits between the execute stage and the data-cache stage, consumes the EXTL interface, and registers it into the TLC interface. It owns a 4-entry fully associative data TLB that translates the memory address computed in execute, and raises a DTLB miss for unmapped memory accesses. DTLB entries are written by instructions flagged `tlbwrite = dtlb` arriving on the same interface.

## Interface
- `DTLB_ENTRIES`, 4: number of DTLB entries; must be a power of two, at least 2.
- `PAGE_BITS`, 12: page offset width. VPN and PPN are each 32−PAGE_BITS = 20 bits.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; one clock; asynchronous, active-high.
- `vm_en` in 1: 1 = translate; 0 = physical address equals virtual address, with no miss.
- `stall` in 1: backpressure from the cache stage; 1 = hold all output registers and TLB state.
- `ex_thread`, `ex_isvalid`, `ex_itlb_miss`, `ex_pc`(32), `ex_data`(32), `ex_mul`(32), `ex_r2`(32), `ex_dst`(5), `ex_isequal`, `ex_flag_mem`, `ex_flag_store`, `ex_flag_isbyte`, `ex_flag_mul`, `ex_flag_reg`, `ex_flag_jump`, `ex_flag_branch`, `ex_flag_iret`, `ex_flag_tlbwrite`(2: 0 off, 1 itlb, 2 dtlb), `ex_rm4`(32), all in: EXTL interface.
- `c_*` out: the same field set as the EXTL interface, registered, plus:
  - `c_paddr` out 32: translated address (`c_data` keeps the virtual address).
  - `c_dtlb_miss` out 1: memory access that missed the DTLB.

## Operation
- Lookup is combinational on `ex_data[31:12]` against all valid entries. `hit` = exactly one valid entry with a matching VPN.
- Physical address: `paddr = {ppn_hit, ex_data[11:0]}` when `vm_en & hit`; `ex_data` when `!vm_en`; `ex_data` (don't-care) on a miss.
- Miss: `miss = ex_isvalid & ex_flag_mem & vm_en & !hit`.
  - A missing instruction is forwarded with `c_dtlb_miss = 1`.
  - `c_isvalid` stays at `ex_isvalid`; the exception stage squashes it.
- DTLB write condition: `ex_isvalid & ex_flag_tlbwrite == 2 & !stall & !ex_itlb_miss`.
- Write data: `vpn = ex_data[31:12]`, `ppn = ex_r2[19:0]`.
- Write target:
  - If the VPN already hits, that entry is overwritten, so duplicates are never created.
  - Otherwise the first invalid entry is used, lowest index first.
  - Otherwise the entry at round-robin pointer `rr` is used, and `rr` increments modulo `DTLB_ENTRIES`.
- `c_flag_tlbwrite` carries the input value through; the itlb code (1) is not acted on here.
- Sequential state per entry: `valid`, `vpn`, `ppn`. Plus `rr` (log2 `DTLB_ENTRIES` bits).
- Write vs. lookup in the same cycle: the lookup uses the pre-write contents. A following instruction sees the new entry.

## Timing
- Latency: 1 cycle from `ex_*` to `c_*` when `stall = 0`.
- `stall = 1`: all `c_*` hold their values; no TLB write; `rr` holds. The EX stage is responsible for holding its own outputs.
- Reset (asynchronous, mid-operation included):
  - All `c_*` outputs go to 0, including `c_isvalid`, `c_dtlb_miss` and `c_flag_tlbwrite` (= off).
  - All entries become invalid; `rr` = 0.
  - The first capture happens on the first rising edge after `rst` deasserts.
- Wrap-around: with all entries valid, the 5th distinct write replaces entry 0, the 6th replaces entry 1, and so on.
- Invalid slots (`ex_isvalid = 0`) never write the TLB and never raise a miss, but are still registered.

## Configuration
- `STAGE_TL_FLUSH_EN`:
  - Defined: adds input port `dtlb_flush` (1 bit). When it is high on a clock edge, all entries are invalidated and `rr` is cleared to 0. It overrides a simultaneous write, and it takes effect even when `stall = 1`. The lookup in that cycle still uses the old contents.
  - Undefined: the port is absent, and entries are cleared only by `rst`.

## Test plan
- Reset: assert `rst` mid-stream with `c_isvalid = 1` -> all `c_*` = 0 immediately, without waiting for a clock edge. After release, a load at 0x00003010 with `vm_en = 1` -> `c_dtlb_miss = 1`.
- Write and hit: dtlb write with `ex_data = 0x00003000`, `ex_r2 = 0x00000ABC`, then a load at 0x00003010 -> `c_paddr = 0x00ABC010`, `c_dtlb_miss = 0`, `c_data = 0x00003010`.
- Replacement: write VPNs 1..5 in order -> VPN 1 misses, VPNs 2..5 hit, `rr` = 1.
- Duplicate write: rewrite VPN 3 with PPN 0x00077 -> no entry replaced, and a load to page 3 yields PPN 0x00077.
- Stall: a write is presented while `stall = 1` for 3 cycles -> outputs are frozen for those 3 cycles, and the write occurs only on the cycle `stall` drops. `vm_en = 0`: a load at 0x12345678 -> `c_paddr = 0x12345678`, no miss.
- Flush (`STAGE_TL_FLUSH_EN`): with 4 valid entries, pulse `dtlb_flush` -> the next load to any previously mapped page gives `c_dtlb_miss = 1`, and the next write goes to entry 0.
